fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Front end of the multi-cycle MIPS datapath; consumes the control unit's PC and IR strobes.
//  Holds PC, instruction register (IR) and memory data register (MDR).
//  Forms the unified memory address (IorD) and the next PC (PCSrc).
//  Gates PC updates with PCWrite | (Branch & Zero). Counts fetched instructions.
// PARAMETERS
//  BIT_WIDTH  32            datapath/address width
//  RESET_PC   32'h0040_0000 PC value after reset
//  CNT_WIDTH  32            width of fetched-instruction counter
// PORTS
//  clk         in   1          system clock, all state on rising edge
//  rst         in   1          synchronous reset, active-high
//  PCWrite     in   1          unconditional PC update strobe
//  Branch      in   1          conditional PC update strobe
//  Zero        in   1          ALU zero flag, same cycle as Branch
//  PCSrc       in   2          next-PC select (pc_src_t)
//  IorD        in   1          0: MemAddr=PC, 1: MemAddr=ALUOut
//  IRWrite     in   1          load IR from MemRdData
//  ALUResult   in   BIT_WIDTH  combinational ALU result (PC+4, branch target)
//  ALUOut      in   BIT_WIDTH  registered ALU result
//  MemRdData   in   BIT_WIDTH  unified memory read data
//  PC          out  BIT_WIDTH  current program counter
//  MemAddr     out  BIT_WIDTH  unified memory address, combinational
//  Instr       out  BIT_WIDTH  IR contents
//  Op, Funct   out  6 each     Instr[31:26], Instr[5:0] to control unit
//  MemData     out  BIT_WIDTH  MDR contents
//  InstrCount  out  CNT_WIDTH  number of IR loads since reset
//  pc_misalign out  1          sticky misaligned-PC flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (sync, overrides everything incl. mid-instruction): PC=RESET_PC, Instr=0, MemData=0,
//    InstrCount=0, pc_misalign=0. Op/Funct follow Instr, so 0 after reset.
//  - PCEn = PCWrite | (Branch & Zero). On PCEn, PC <= next_pc at next edge (1-cycle latency).
//  - next_pc: 00 ALUResult; 01 ALUOut; 10 {PC[31:28], Instr[25:0], 2'b00}; 11 reserved -> PC holds
//    even if PCEn.
//  - Branch & !Zero & !PCWrite: PC holds.
//  - IRWrite: Instr <= MemRdData. MemData <= MemRdData every cycle IRWrite=0; holds while IRWrite=1.
//  - InstrCount +1 on each IRWrite cycle; wraps from all-ones to 0, no saturation.
//  - IRWrite and PCEn in same cycle (fetch state): both update. Jump target uses old Instr.
//  - No internal FSM sequencing; the sole state machine is the control unit. This block is
//    pure strobe-driven registers.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: PCEn with next_pc[1:0]!=0 -> PC holds, pc_misalign<=1.
//    pc_misalign stays set until rst.
//  Undefined: PC loaded unchecked; pc_misalign tied 0.
// STRUCTURE
//  mips_pkg: pc_src_t enum (PCSRC_ALU, PCSRC_ALUOUT, PCSRC_JUMP, PCSRC_RSVD); OP_J/OP_BEQ constants;
//    RESET_PC default.
//  Sub-module en_reg #(WIDTH, RST_VAL): sync-reset enable flop, instanced for PC, IR, MDR.
// TESTING
//  1 rst=1 two cycles, then release -> PC=0x00400000, Instr=0, InstrCount=0, MemAddr=PC.
//  2 IRWrite=1, PCWrite=1, PCSrc=00, ALUResult=PC+4, MemRdData=0x08100004 ->
//    next edge Instr=0x08100004, Op=2, PC=0x00400004, InstrCount=1.
//  3 PCWrite=1, PCSrc=10 with Instr above, PC=0x00400004 -> PC=0x00400010.
//  4 Branch=1, Zero=0, ALUOut=0x00400100, PCSrc=01 -> PC unchanged; repeat with Zero=1 -> PC=0x00400100.
//  5 IorD=1, ALUOut=0x10010000 -> MemAddr=0x10010000 same cycle.
//    IRWrite=0 -> MemData tracks MemRdData after 1 edge.
//  6 MISALIGN_TRAP_EN: PCWrite=1, PCSrc=00, ALUResult=0x00400006 -> PC holds, pc_misalign=1 until rst.
//    Also assert rst mid-sequence -> all reset values next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the multi-cycle MIPS front end
package mips_pkg;

   // Next-PC source select driven by the control unit
   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10,
      PCSRC_RSVD   = 2'b11
   } pc_src_t;

   localparam logic [5:0]  OP_J             = 6'h02;
   localparam logic [5:0]  OP_BEQ           = 6'h04;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

endpackage

// File: rtl/en_reg.sv
// rtl/en_reg.sv - enable flop with synchronous active-high reset
module en_reg #(
   parameter int             WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Reset wins over load; otherwise load only when enabled
   always_ff @(posedge clk) begin
      if (rst)
         q <= RST_VAL;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - PC/IR/MDR front end; optional MISALIGN_TRAP_EN blocks misaligned PC loads
module fetch_pc_unit
   import mips_pkg::*;
#(
   parameter int              BIT_WIDTH = 32,
   parameter logic [BIT_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 PCWrite,
   input  logic                 Branch,
   input  logic                 Zero,
   input  logic [1:0]           PCSrc,
   input  logic                 IorD,
   input  logic                 IRWrite,
   input  logic [BIT_WIDTH-1:0] ALUResult,
   input  logic [BIT_WIDTH-1:0] ALUOut,
   input  logic [BIT_WIDTH-1:0] MemRdData,
   output logic [BIT_WIDTH-1:0] PC,
   output logic [BIT_WIDTH-1:0] MemAddr,
   output logic [BIT_WIDTH-1:0] Instr,
   output logic [5:0]           Op,
   output logic [5:0]           Funct,
   output logic [BIT_WIDTH-1:0] MemData,
   output logic [CNT_WIDTH-1:0] InstrCount,
   output logic                 pc_misalign
);

   logic                 pc_en;
   logic                 pc_load;
   logic                 next_valid;
   logic [BIT_WIDTH-1:0] next_pc;

   assign pc_en   = PCWrite | (Branch & Zero);
   assign MemAddr = IorD ? ALUOut : PC;
   assign Op      = Instr[31:26];
   assign Funct   = Instr[5:0];

   // Next-PC mux; the reserved encoding never loads so PC holds even with pc_en
   always_comb begin
      next_pc    = PC;
      next_valid = 1'b1;
      case (pc_src_t'(PCSrc))
         PCSRC_ALU:    next_pc = ALUResult;
         PCSRC_ALUOUT: next_pc = ALUOut;
         PCSRC_JUMP:   next_pc = {PC[BIT_WIDTH-1:28], Instr[25:0], 2'b00};
         default:      next_valid = 1'b0;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic misalign_hit;

   assign misalign_hit = pc_en & next_valid & (next_pc[1:0] != 2'b00);
   assign pc_load      = pc_en & next_valid & ~misalign_hit;

   // Sticky trap flag: set by any blocked misaligned load, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst)
         pc_misalign <= 1'b0;
      else if (misalign_hit)
         pc_misalign <= 1'b1;
   end
`else
   assign pc_load     = pc_en & next_valid;
   assign pc_misalign = 1'b0;
`endif

   en_reg #(.WIDTH(BIT_WIDTH), .RST_VAL(RESET_PC)) u_pc (
      .clk (clk),
      .rst (rst),
      .en  (pc_load),
      .d   (next_pc),
      .q   (PC)
   );

   en_reg #(.WIDTH(BIT_WIDTH), .RST_VAL('0)) u_ir (
      .clk (clk),
      .rst (rst),
      .en  (IRWrite),
      .d   (MemRdData),
      .q   (Instr)
   );

   // MDR captures every non-fetch cycle so data reads are available one edge later
   en_reg #(.WIDTH(BIT_WIDTH), .RST_VAL('0)) u_mdr (
      .clk (clk),
      .rst (rst),
      .en  (~IRWrite),
      .d   (MemRdData),
      .q   (MemData)
   );

   // Fetch counter, free-running wrap on overflow
   always_ff @(posedge clk) begin
      if (rst)
         InstrCount <= '0;
      else if (IRWrite)
         InstrCount <= InstrCount + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - scoreboard bench for fetch_pc_unit
module tb_fetch_pc_unit;

   localparam logic [31:0] RPC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        PCWrite = 1'b0, Branch = 1'b0, Zero = 1'b0, IorD = 1'b0, IRWrite = 1'b0;
   logic [1:0]  PCSrc = 2'b00;
   logic [31:0] ALUResult = '0, ALUOut = '0, MemRdData = '0;
   logic [31:0] PC, MemAddr, Instr, MemData;
   logic [5:0]  Op, Funct;
   logic [3:0]  InstrCount;
   logic        pc_misalign;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] mdr;
      logic [3:0]  cnt;
      logic        mis;
   } exp_t;

   exp_t sb[$];

   logic [31:0] m_pc, m_ir, m_mdr;
   logic [3:0]  m_cnt;
   logic        m_mis;

   fetch_pc_unit #(.BIT_WIDTH(32), .RESET_PC(RPC), .CNT_WIDTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .PCWrite     (PCWrite),
      .Branch      (Branch),
      .Zero        (Zero),
      .PCSrc       (PCSrc),
      .IorD        (IorD),
      .IRWrite     (IRWrite),
      .ALUResult   (ALUResult),
      .ALUOut      (ALUOut),
      .MemRdData   (MemRdData),
      .PC          (PC),
      .MemAddr     (MemAddr),
      .Instr       (Instr),
      .Op          (Op),
      .Funct       (Funct),
      .MemData     (MemData),
      .InstrCount  (InstrCount),
      .pc_misalign (pc_misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc  = RPC;
      m_ir  = '0;
      m_mdr = '0;
      m_cnt = '0;
      m_mis = 1'b0;
   endtask

   // Reference behaviour for one clock edge given the current inputs
   task automatic model_step();
      logic        pcen, valid;
      logic [31:0] np;
      pcen  = PCWrite | (Branch & Zero);
      valid = 1'b1;
      np    = m_pc;
      case (PCSrc)
         2'b00:   np = ALUResult;
         2'b01:   np = ALUOut;
         2'b10:   np = {m_pc[31:28], m_ir[25:0], 2'b00};
         default: valid = 1'b0;
      endcase
      if (rst) begin
         model_reset();
      end else begin
         if (pcen && valid) begin
`ifdef MISALIGN_TRAP_EN
            if (np[1:0] != 2'b00) m_mis = 1'b1;
            else                  m_pc  = np;
`else
            m_pc = np;
`endif
         end
         if (IRWrite) begin
            m_ir  = MemRdData;
            m_cnt = m_cnt + 4'd1;
         end else begin
            m_mdr = MemRdData;
         end
      end
   endtask

   task automatic sb_compare();
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check({e.tag, ".pc"},    PC,                e.pc);
      check({e.tag, ".instr"}, Instr,             e.instr);
      check({e.tag, ".op"},    {26'd0, Op},       {26'd0, e.instr[31:26]});
      check({e.tag, ".funct"}, {26'd0, Funct},    {26'd0, e.instr[5:0]});
      check({e.tag, ".mdr"},   MemData,           e.mdr);
      check({e.tag, ".cnt"},   {28'd0, InstrCount}, {28'd0, e.cnt});
      check({e.tag, ".mis"},   {31'd0, pc_misalign}, {31'd0, e.mis});
   endtask

   // One cycle: drive at negedge, check combinational address, push expectation, compare after edge
   task automatic cyc(input string tag, input logic r, input logic pcw, input logic br,
                      input logic z, input logic [1:0] src, input logic iord, input logic irw,
                      input logic [31:0] alur, input logic [31:0] aluo, input logic [31:0] rd);
      exp_t e;
      @(negedge clk);
      rst = r; PCWrite = pcw; Branch = br; Zero = z; PCSrc = src;
      IorD = iord; IRWrite = irw; ALUResult = alur; ALUOut = aluo; MemRdData = rd;
      #1;
      check({tag, ".memaddr"}, MemAddr, iord ? aluo : m_pc);
      model_step();
      e.tag = tag; e.pc = m_pc; e.instr = m_ir; e.mdr = m_mdr; e.cnt = m_cnt; e.mis = m_mis;
      sb.push_back(e);
      @(posedge clk);
      #1;
      sb_compare();
   endtask

   initial begin
      // Reset held for two edges before any checking
      rst = 1'b1;
      repeat (2) @(posedge clk);
      model_reset();
      cyc("reset", 1'b1, 0, 0, 0, 2'b00, 0, 0, '0, '0, '0);
      check("reset.pc_const", PC, 32'h0040_0000);
      check("reset.cnt_const", {28'd0, InstrCount}, 32'd0);

      // Fetch: IR load and PC+4 in the same edge
      cyc("fetch", 0, 1, 0, 0, 2'b00, 0, 1, 32'h0040_0004, '0, 32'h0810_0004);
      check("fetch.pc_const", PC, 32'h0040_0004);
      check("fetch.op_const", {26'd0, Op}, 32'd2);

      // Jump using the instruction just fetched
      cyc("jump", 0, 1, 0, 0, 2'b10, 0, 0, '0, '0, 32'h1111_2222);
      check("jump.pc_const", PC, 32'h0040_0010);

      // Branch not taken, then taken
      cyc("bnt", 0, 0, 1, 0, 2'b01, 0, 0, '0, 32'h0040_0100, 32'h3333_4444);
      check("bnt.pc_const", PC, 32'h0040_0010);
      cyc("bt", 0, 0, 1, 1, 2'b01, 0, 0, '0, 32'h0040_0100, 32'h5555_6666);
      check("bt.pc_const", PC, 32'h0040_0100);

      // Data access through ALUOut; MDR capture
      cyc("data", 0, 0, 0, 0, 2'b00, 1, 0, '0, 32'h1001_0000, 32'hdead_beef);
      check("data.mdr_const", MemData, 32'hdead_beef);

      // Reserved select holds PC even when strobed
      cyc("rsvd", 0, 1, 0, 0, 2'b11, 0, 0, 32'h0000_1000, 32'h0000_2000, 32'h0);

      // Misaligned target: trapped or loaded depending on build
      cyc("misal", 0, 1, 0, 0, 2'b00, 0, 0, 32'h0040_0006, '0, 32'h0);
      cyc("misal2", 0, 0, 0, 0, 2'b00, 0, 0, '0, '0, 32'h0);

      // Reset mid-instruction with every strobe active
      cyc("midrst", 1, 1, 1, 1, 2'b00, 0, 1, 32'h0040_0200, '0, 32'hffff_ffff);

      // Counter wrap at 4 bits
      for (int i = 0; i < 17; i++)
         cyc("wrap", 0, 0, 0, 0, 2'b00, 0, 1, '0, '0, 32'h0000_0020 + i);

      // Random strobe traffic with occasional reset
      for (int i = 0; i < 60; i++)
         cyc("rand", ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
             2'($urandom), 1'($urandom), 1'($urandom),
             $urandom & ((i % 4 == 0) ? 32'hffff_ffff : 32'hffff_fffc),
             $urandom, $urandom);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
